rtos_mem_bridge: RTL and testbench

Memory-side responder for the RTOS unit's context-memory ports (`mem_wr`, `mem_rd_addr`, `mem_rd_data`). It consumes the unit's store and load requests and issues them as word accesses on an OBI-style data master port. That port feeds the system data interconnect alongside the core LSU. Read responses return to the RTOS unit in order through a small response FIFO.

---
 rtl/rtos_mem_bridge.sv | 146 ++++++++++++++
 tb/tb_rtos_mem_bridge.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtos_mem_bridge.sv
// rtl/rtos_mem_bridge.sv - RTOS context-memory ports to OBI data master bridge
// Stores/loads are staged in one A-phase register; read data returns through an in-order FIFO.
module rtos_mem_bridge #(
   parameter int MAX_OUTSTANDING  = 2,
   parameter int RDATA_FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [63:0] mem_wr,
   input  logic        RDY_mem_wr,
   output logic        EN_mem_wr,
   input  logic [31:0] mem_rd_addr,
   input  logic        RDY_mem_rd_addr,
   output logic        EN_mem_rd_addr,
   output logic [31:0] mem_rd_data_d,
   input  logic        RDY_mem_rd_data,
   output logic        EN_mem_rd_data,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i,
   output logic        busy_o,
   output logic        err_o
);
   localparam int TPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int RPW = (RDATA_FIFO_DEPTH > 1) ? $clog2(RDATA_FIFO_DEPTH) : 1;
   localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(RDATA_FIFO_DEPTH + 1);

   logic            r_areq_valid;
   logic            r_areq_we;
   logic [31:0]     r_areq_addr;
   logic [31:0]     r_areq_wdata;
   logic [OCW-1:0]  r_outst;
   logic [OCW-1:0]  r_rd_outst;
   logic            r_type_mem [MAX_OUTSTANDING];
   logic [TPW-1:0]  r_type_wptr;
   logic [TPW-1:0]  r_type_rptr;
   logic [31:0]     r_fifo_mem [RDATA_FIFO_DEPTH];
   logic [RPW-1:0]  r_fifo_wptr;
   logic [RPW-1:0]  r_fifo_rptr;
   logic [FCW-1:0]  r_fifo_cnt;
   logic            r_err;

   logic            w_gnt;
   logic            w_rsp;
   logic            w_rsp_is_rd;
   logic            w_fifo_push;
   logic            w_fifo_pop;
   logic            w_fifo_empty;
   logic            w_stage_free;
   logic [31:0]     w_slot_sum;
   logic [31:0]     w_rd_sum;
   logic            w_slot_ok;
   logic            w_rd_ok;

   function automatic logic [TPW-1:0] f_tinc(input logic [TPW-1:0] p);
      return (p == TPW'(MAX_OUTSTANDING - 1)) ? '0 : p + TPW'(1);
   endfunction

   function automatic logic [RPW-1:0] f_rinc(input logic [RPW-1:0] p);
      return (p == RPW'(RDATA_FIFO_DEPTH - 1)) ? '0 : p + RPW'(1);
   endfunction

   assign w_gnt        = r_areq_valid & data_gnt_i;
   assign w_rsp        = data_rvalid_i & (r_outst != '0);
   assign w_rsp_is_rd  = r_type_mem[r_type_rptr];
   assign w_fifo_push  = w_rsp & w_rsp_is_rd;
   assign w_fifo_empty = (r_fifo_cnt == '0);
   assign w_fifo_pop   = ~w_fifo_empty & RDY_mem_rd_data;
   assign w_stage_free = ~r_areq_valid | w_gnt;

   // The staged request is counted whether or not it is granted now, and a response
   // arriving this cycle frees its slot, so the bus never sees more than MAX_OUTSTANDING.
   assign w_slot_sum = 32'(r_outst) + 32'(r_areq_valid) - 32'(w_rsp);
   assign w_slot_ok  = w_slot_sum < MAX_OUTSTANDING;
   // Every read in flight holds a FIFO slot so a response always has room.
   assign w_rd_sum   = 32'(r_rd_outst) + 32'(r_areq_valid & ~r_areq_we) + 32'(r_fifo_cnt);
   assign w_rd_ok    = w_rd_sum < RDATA_FIFO_DEPTH;

   assign EN_mem_wr      = RDY_mem_wr & w_stage_free & w_slot_ok;
   assign EN_mem_rd_addr = RDY_mem_rd_addr & ~RDY_mem_wr & w_stage_free & w_slot_ok & w_rd_ok;
   assign EN_mem_rd_data = w_fifo_pop;
   assign mem_rd_data_d  = w_fifo_empty ? '0 : r_fifo_mem[r_fifo_rptr];

   assign data_req_o   = r_areq_valid;
   assign data_we_o    = r_areq_we;
   assign data_be_o    = {4{r_areq_valid}};
   assign data_addr_o  = r_areq_addr;
   assign data_wdata_o = r_areq_wdata;
   assign busy_o       = r_areq_valid | (r_outst != '0) | ~w_fifo_empty;
   assign err_o        = r_err;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_areq_valid <= 1'b0;
         r_areq_we    <= 1'b0;
         r_areq_addr  <= '0;
         r_areq_wdata <= '0;
      end else if (EN_mem_wr) begin
         r_areq_valid <= 1'b1;
         r_areq_we    <= 1'b1;
         r_areq_addr  <= mem_wr[63:32] & 32'hFFFF_FFFC;
         r_areq_wdata <= mem_wr[31:0];
      end else if (EN_mem_rd_addr) begin
         r_areq_valid <= 1'b1;
         r_areq_we    <= 1'b0;
         r_areq_addr  <= mem_rd_addr & 32'hFFFF_FFFC;
         r_areq_wdata <= '0;
      end else if (w_gnt) begin
         r_areq_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_outst     <= '0;
         r_rd_outst  <= '0;
         r_type_wptr <= '0;
         r_type_rptr <= '0;
         r_fifo_wptr <= '0;
         r_fifo_rptr <= '0;
         r_fifo_cnt  <= '0;
         r_err       <= 1'b0;
      end else begin
         r_outst    <= r_outst + OCW'(w_gnt) - OCW'(w_rsp);
         r_rd_outst <= r_rd_outst + OCW'(w_gnt & ~r_areq_we) - OCW'(w_fifo_push);
         r_fifo_cnt <= r_fifo_cnt + FCW'(w_fifo_push) - FCW'(w_fifo_pop);
         if (w_gnt)       r_type_wptr <= f_tinc(r_type_wptr);
         if (w_rsp)       r_type_rptr <= f_tinc(r_type_rptr);
         if (w_fifo_push) r_fifo_wptr <= f_rinc(r_fifo_wptr);
         if (w_fifo_pop)  r_fifo_rptr <= f_rinc(r_fifo_rptr);
         if (data_rvalid_i && (r_outst == '0)) r_err <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_gnt)       r_type_mem[r_type_wptr] <= ~r_areq_we;
      if (w_fifo_push) r_fifo_mem[r_fifo_wptr] <= data_rdata_i;
   end

endmodule

// File: tb/tb_rtos_mem_bridge.sv
// tb/tb_rtos_mem_bridge.sv - scoreboard bench for rtos_mem_bridge with an OBI responder model
module tb_rtos_mem_bridge;
   localparam int MAXO = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [63:0] mem_wr;
   logic        RDY_mem_wr;
   logic        EN_mem_wr;
   logic [31:0] mem_rd_addr;
   logic        RDY_mem_rd_addr;
   logic        EN_mem_rd_addr;
   logic [31:0] mem_rd_data_d;
   logic        RDY_mem_rd_data;
   logic        EN_mem_rd_data;
   logic        data_req_o;
   logic        data_gnt_i;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;
   logic        busy_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   rtos_mem_bridge #(.MAX_OUTSTANDING(MAXO), .RDATA_FIFO_DEPTH(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .mem_wr(mem_wr), .RDY_mem_wr(RDY_mem_wr), .EN_mem_wr(EN_mem_wr),
      .mem_rd_addr(mem_rd_addr), .RDY_mem_rd_addr(RDY_mem_rd_addr), .EN_mem_rd_addr(EN_mem_rd_addr),
      .mem_rd_data_d(mem_rd_data_d), .RDY_mem_rd_data(RDY_mem_rd_data), .EN_mem_rd_data(EN_mem_rd_data),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
      .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } bus_t;
   typedef struct { int due; logic rd; logic [31:0] addr; } pend_t;

   bus_t        exp_bus[$];
   pend_t       pend[$];
   logic [31:0] exp_rsp[$];
   logic [63:0] wr_q[$];
   logic [31:0] rd_q[$];
   int          gnt_cyc[$];

   int checks = 0, errors = 0, cyc = 0;
   int gnt_delay = 0, rv_lag = 1, req_wait = 0;
   bit rd_ready = 1'b1, spur = 1'b0, drove_rv;
   int bench_outst = 0, peak_outst = 0, req_cycles = 0, gnt_cnt = 0, rsp_cnt = 0;
   int en_wr_cyc = -1, en_rd_cyc = -1, rv_rd_cyc = -1, en_rsp_cyc = -1;
   int base_a, base_b;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return (a == 32'h0000_2000) ? 32'h1234_5678 : (a ^ 32'h5A5A_0F0F);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_q.push_back({a, d});
      exp_bus.push_back('{1'b1, a & 32'hFFFF_FFFC, d});
   endtask

   task automatic push_rd(input logic [31:0] a);
      rd_q.push_back(a);
      exp_bus.push_back('{1'b0, a & 32'hFFFF_FFFC, 32'h0});
      exp_rsp.push_back(mem_model(a & 32'hFFFF_FFFC));
   endtask

   task automatic step(input int n);
      repeat (n) begin @(negedge clk_i); #2; end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk_i); #2; n++;
      end while (n < 300 && (wr_q.size() != 0 || rd_q.size() != 0 || pend.size() != 0 ||
                             exp_bus.size() != 0 || exp_rsp.size() != 0 || busy_o));
      chk({tag, "_busy_clear"}, 32'(busy_o), 32'd0);
      chk({tag, "_drained"}, exp_bus.size() + exp_rsp.size() + pend.size(), 32'd0);
   endtask

   // Request drivers, OBI responder and output monitor: drive at negedge, sample 1 later.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         RDY_mem_wr = 0; RDY_mem_rd_addr = 0; RDY_mem_rd_data = 0;
         mem_wr = '0; mem_rd_addr = '0; data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
         req_wait = 0;
      end else begin
         RDY_mem_wr = (wr_q.size() != 0);
         mem_wr = '0;
         if (RDY_mem_wr) mem_wr = wr_q[0];
         RDY_mem_rd_addr = (rd_q.size() != 0);
         mem_rd_addr = '0;
         if (RDY_mem_rd_addr) mem_rd_addr = rd_q[0];
         RDY_mem_rd_data = rd_ready;
         data_gnt_i = data_req_o && (req_wait >= gnt_delay);
         drove_rv = 1'b0;
         data_rvalid_i = 1'b0;
         data_rdata_i = '0;
         if (spur) begin
            data_rvalid_i = 1'b1; data_rdata_i = 32'hDEAD_0000; spur = 1'b0;
         end else if (pend.size() != 0 && pend[0].due <= cyc) begin
            data_rvalid_i = 1'b1; drove_rv = 1'b1;
            data_rdata_i = pend[0].rd ? mem_model(pend[0].addr) : 32'hBAD0_BAD0;
         end
         #1;
         if (rst_ni) begin
            if (data_req_o) begin
               req_cycles++;
               if (exp_bus.size() == 0) chk("bus_unexpected_req", 32'd1, 32'd0);
               else begin
                  chk("bus_addr", data_addr_o, exp_bus[0].addr);
                  chk("bus_we", 32'(data_we_o), 32'(exp_bus[0].we));
                  chk("bus_be", 32'(data_be_o), 32'hF);
                  if (exp_bus[0].we) chk("bus_wdata", data_wdata_o, exp_bus[0].wdata);
                  if (data_gnt_i) begin
                     pend.push_back('{cyc + rv_lag, !exp_bus[0].we, exp_bus[0].addr});
                     void'(exp_bus.pop_front());
                     bench_outst++; gnt_cnt++; gnt_cyc.push_back(cyc);
                  end
               end
               req_wait = data_gnt_i ? 0 : req_wait + 1;
            end else req_wait = 0;
            if (drove_rv) begin
               if (pend[0].rd) rv_rd_cyc = cyc;
               void'(pend.pop_front());
               bench_outst--;
            end
            if (bench_outst > peak_outst) peak_outst = bench_outst;
            chk("outstanding_limit", 32'(bench_outst <= MAXO), 32'd1);
            if (EN_mem_rd_data) begin
               chk("rsp_en_needs_rdy", 32'(RDY_mem_rd_data), 32'd1);
               if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
               else chk("rsp_data", mem_rd_data_d, exp_rsp.pop_front());
               rsp_cnt++; en_rsp_cyc = cyc;
            end
            if (EN_mem_wr) begin
               chk("en_wr_needs_rdy", 32'(RDY_mem_wr), 32'd1);
               if (wr_q.size() != 0) void'(wr_q.pop_front());
               en_wr_cyc = cyc;
            end
            if (EN_mem_rd_addr) begin
               chk("store_priority", 32'(RDY_mem_wr), 32'd0);
               if (rd_q.size() != 0) void'(rd_q.pop_front());
               en_rd_cyc = cyc;
            end
         end
      end
      cyc++;
   end

   initial begin
      rst_ni = 1'b1;
      RDY_mem_wr = 0; RDY_mem_rd_addr = 0; RDY_mem_rd_data = 0; mem_wr = '0; mem_rd_addr = '0;
      data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
      #2 rst_ni = 1'b0;
      #1;
      chk("reset_ctrl", 32'({EN_mem_wr, EN_mem_rd_addr, EN_mem_rd_data, data_req_o, data_we_o, busy_o, err_o}), 32'd0);
      chk("reset_addr", data_addr_o, 32'd0);
      chk("reset_wdata", data_wdata_o, 32'd0);
      chk("reset_be", 32'(data_be_o), 32'd0);
      chk("reset_rdata", mem_rd_data_d, 32'd0);
      repeat (2) @(negedge clk_i);
      #3 rst_ni = 1'b1;
      step(2);
      chk("idle_rdata", mem_rd_data_d, 32'd0);

      // Single store with immediate grant, response 2 cycles later
      gnt_delay = 0; rv_lag = 2; base_a = req_cycles; base_b = rsp_cnt;
      push_wr(32'h0000_1004, 32'hDEAD_BEEF);
      wait_idle("t1");
      chk("t1_req_cycles", req_cycles - base_a, 32'd1);
      chk("t1_no_rsp", rsp_cnt - base_b, 32'd0);

      // Unaligned load held off by 5 cycles of no grant
      gnt_delay = 5; rv_lag = 1; base_a = req_cycles; base_b = rsp_cnt;
      push_rd(32'h0000_2002);
      wait_idle("t2");
      chk("t2_req_cycles", req_cycles - base_a, 32'd6);
      chk("t2_rsp_count", rsp_cnt - base_b, 32'd1);
      chk("t2_rsp_latency", en_rsp_cyc - rv_rd_cyc, 32'd1);

      // Store and load presented together
      gnt_delay = 0;
      push_wr(32'h0000_5008, 32'hCAFE_F00D);
      push_rd(32'h0000_500C);
      wait_idle("t3");
      chk("t3_en_order", en_rd_cyc - en_wr_cyc, 32'd1);

      // Four loads against a stalled consumer
      rd_ready = 1'b0; base_a = gnt_cnt; base_b = rsp_cnt;
      push_rd(32'h0000_3000); push_rd(32'h0000_3005); push_rd(32'h0000_300A); push_rd(32'h0000_300C);
      step(20);
      chk("t4_issued_blocked", gnt_cnt - base_a, 32'd2);
      chk("t4_busy_blocked", 32'(busy_o), 32'd1);
      chk("t4_head_visible", mem_rd_data_d, exp_rsp[0]);
      rd_ready = 1'b1;
      wait_idle("t4");
      chk("t4_issued_total", gnt_cnt - base_a, 32'd4);
      chk("t4_rsp_count", rsp_cnt - base_b, 32'd4);

      // Continuous grant, responses lagging one cycle, 8 mixed requests
      gnt_cyc.delete(); base_a = gnt_cnt;
      for (int i = 0; i < 4; i++) push_wr(32'h0000_6000 + 32'(4 * i), $urandom);
      for (int i = 0; i < 4; i++) push_rd(32'h0000_7000 + 32'(4 * i));
      wait_idle("t5");
      chk("t5_grants", gnt_cnt - base_a, 32'd8);
      if (gnt_cyc.size() >= 4) chk("t5_store_b2b", gnt_cyc[3] - gnt_cyc[0], 32'd3);
      else chk("t5_store_b2b_count", gnt_cyc.size(), 32'd4);

      // Slow responses: the outstanding limit must throttle issue
      rv_lag = 5; peak_outst = 0; base_a = gnt_cnt;
      for (int i = 0; i < 4; i++) push_wr(32'h0000_8000 + 32'(4 * i), 32'h1111_0000 + 32'(i));
      wait_idle("t5b");
      chk("t5b_peak_outst", peak_outst, 32'd2);
      chk("t5b_grants", gnt_cnt - base_a, 32'd4);
      chk("t5b_err_clear", 32'(err_o), 32'd0);

      // Spurious response at idle, then asynchronous reset mid-request
      rv_lag = 1; gnt_delay = 1000;
      push_rd(32'h0000_4000);
      step(3);
      chk("t6_req_pending", 32'(data_req_o), 32'd1);
      spur = 1'b1;
      step(3);
      chk("t6_err_set", 32'(err_o), 32'd1);
      step(4);
      chk("t6_err_held", 32'(err_o), 32'd1);
      @(negedge clk_i);
      #3 rst_ni = 1'b0;
      #1;
      chk("t6_async_ctrl", 32'({EN_mem_wr, EN_mem_rd_addr, EN_mem_rd_data, data_req_o, data_we_o, busy_o, err_o}), 32'd0);
      chk("t6_async_addr", data_addr_o, 32'd0);
      chk("t6_async_be", 32'(data_be_o), 32'd0);
      wr_q.delete(); rd_q.delete(); exp_bus.delete(); exp_rsp.delete(); pend.delete();
      bench_outst = 0; gnt_delay = 0;
      repeat (2) @(negedge clk_i);
      #3 rst_ni = 1'b1;
      step(3);
      chk("t6_post_err", 32'(err_o), 32'd0);
      chk("t6_post_busy", 32'(busy_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion expected finish before timeout");
      $fatal(1, "watchdog");
   end

endmodule
